// File: rtl/mdr_pkg.sv
// Shared types for the memory data register block: FSM states and access-size codes.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } mdr_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_FULL = 2'b10;

    // Size code 2'b11 behaves exactly like a full-width access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? SZ_FULL : sz;
    endfunction

endpackage

// File: rtl/mdr_extend.sv
// Purpose: sign/zero extension of memory read data and byte-lane enable generation.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module mdr_extend
    import mdr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   raw,
    input  logic [1:0]         size,
    input  logic               sign,
    output logic [WIDTH-1:0]   ext,
    output logic [WIDTH/8-1:0] be
);

    logic [1:0] sz;

    assign sz = norm_size(size);

    // Widen the low byte or half to the full word; the fill bit is the source MSB when signed, else zero.
    always_comb begin
        ext = raw;
        case (sz)
            SZ_BYTE: for (int b = 8; b < WIDTH; b++) ext[b] = sign & raw[7];
            SZ_HALF: for (int b = 16; b < WIDTH; b++) ext[b] = sign & raw[15];
            default: ext = raw;
        endcase
    end

    // Enabled lanes are always the lowest ones, counted up from lane 0.
    always_comb begin
        be = '0;
        case (sz)
            SZ_BYTE: be[0]   = 1'b1;
            SZ_HALF: be[1:0] = 2'b11;
            default: be      = '1;
        endcase
    end

endmodule

// File: rtl/mdr_bus_if.sv
// Purpose: memory data register with a single-outstanding read/write handshake; optional timeout via MDR_TIMEOUT_EN.
// Latency: bus load 1 cycle; start-to-done at least 3 cycles (start cycle, >=1 wait cycle, done cycle).
// Backpressure: holds mem_req in the wait state until mem_ack (or TIMEOUT cycles when MDR_TIMEOUT_EN); starts ignored while busy.
module mdr_bus_if
    import mdr_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [WIDTH-1:0]   bus_in,
    input  logic               mdr_in,
    input  logic               rd_start,
    input  logic               wr_start,
    input  logic [1:0]         size,
    input  logic               sign,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_ack,
    output logic               mem_req,
    output logic               mem_we,
    output logic [WIDTH/8-1:0] mem_be,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [WIDTH-1:0]   mdr_out,
    output logic               busy,
    output logic               done,
    output logic               err
);

    mdr_state_t         state;
    logic [WIDTH-1:0]   mdr_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic [1:0]         ext_size;
    logic [WIDTH-1:0]   ext_dat;
    logic [WIDTH/8-1:0] be_dat;

`ifdef MDR_TIMEOUT_EN
    localparam int             CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] to_cnt;
    logic          err_q;

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mdr_out   = mdr_q;
    assign mem_wdata = mdr_q;

    // In IDLE the live size drives the lane enables for the request; afterwards the latched size drives extension.
    assign ext_size = (state == ST_IDLE) ? size : size_q;

    mdr_extend #(
        .WIDTH (WIDTH)
    ) u_extend (
        .raw  (mem_rdata),
        .size (ext_size),
        .sign (sign_q),
        .ext  (ext_dat),
        .be   (be_dat)
    );

    // Transfer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            mdr_q   <= '0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
`ifdef MDR_TIMEOUT_EN
            to_cnt  <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    // A bus load alongside rd_start is kept, but the read result overwrites it later.
                    if (mdr_in) mdr_q <= bus_in;
                    if (rd_start || wr_start) begin
                        state   <= rd_start ? ST_RD_WAIT : ST_WR_WAIT;
                        size_q  <= size;
                        sign_q  <= sign;
                        mem_req <= 1'b1;
                        mem_we  <= ~rd_start;
                        mem_be  <= be_dat;
                        busy    <= 1'b1;
`ifdef MDR_TIMEOUT_EN
                        to_cnt  <= '0;
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (mem_ack) begin
                        if (state == ST_RD_WAIT) mdr_q <= ext_dat;
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        done    <= 1'b1;
                    end
`ifdef MDR_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state   <= ST_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        done    <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        to_cnt  <= to_cnt + CW'(1);
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_bus_if.sv
// Purpose: scoreboard bench for mdr_bus_if (WIDTH=32, TIMEOUT=4); timeout cases build only with MDR_TIMEOUT_EN.
// Latency: stimulus issues at posedge+1, monitor samples on negedge.
// Backpressure: the bench acts as memory and returns mem_ack after a chosen delay.
module tb_mdr_bus_if;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] bus_in;
    logic        mdr_in, rd_start, wr_start, sign, mem_ack;
    logic [1:0]  size;
    logic [31:0] mem_rdata;
    logic        mem_req, mem_we, busy, done, err;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mdr_out;

    mdr_bus_if #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .clr(clr), .bus_in(bus_in), .mdr_in(mdr_in),
        .rd_start(rd_start), .wr_start(wr_start), .size(size), .sign(sign),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mdr_out(mdr_out),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [31:0] mdr; logic err; } done_t;

    req_t        exp_req[$];
    done_t       exp_done[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          done_cnt   = 0;
    int          n_exp_done = 0;
    logic [31:0] model_mdr  = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference extension by arithmetic on the low field value.
    function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [1:0] sz, input logic sg);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = d % 32'd256;
            if (sg && v >= 32'd128) v = v - 32'd256;
        end else if (sz == 2'b01) begin
            v = d % 32'd65536;
            if (sg && v >= 32'd32768) v = v - 32'd65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz);
        case (sz)
            2'b00:   return 4'h1;
            2'b01:   return 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    // Monitor: pops expected requests when mem_req rises and expected completions on done.
    initial begin
        req_t  cur;
        done_t d;
        logic  prev_req = 1'b0;
        cur = '{we: 1'b0, be: 4'h0, wdata: 32'h0};
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                check("req_expected", 32'(exp_req.size() > 0), 32'd1);
                if (exp_req.size() > 0) cur = exp_req.pop_front();
            end
            if (mem_req) begin
                check("mem_we", 32'(mem_we), 32'(cur.we));
                check("mem_be", 32'(mem_be), 32'(cur.be));
                check("mem_wdata", mem_wdata, cur.wdata);
                check("busy_in_wait", 32'(busy), 32'd1);
            end else begin
                check("mem_be_idle", 32'(mem_be), 32'd0);
            end
            if (done) begin
                done_cnt++;
                check("done_expected", 32'(exp_done.size() > 0), 32'd1);
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    check("done_mdr", mdr_out, d.mdr);
                    check("done_err", 32'(err), 32'(d.err));
                    check("done_busy", 32'(busy), 32'd1);
                end
            end
            prev_req = mem_req;
        end
    end

    task automatic junk_inputs();
        rd_start = 1'($urandom_range(0, 1));
        wr_start = 1'($urandom_range(0, 1));
        mdr_in   = 1'($urandom_range(0, 1));
        bus_in   = $urandom;
        size     = 2'($urandom_range(0, 3));
        sign     = 1'($urandom_range(0, 1));
    endtask

    // One operation: optional bus load, optional read/write acked after dly wait cycles.
    task automatic txn(input logic rd, input logic wr, input logic mi, input logic [31:0] bi,
                       input logic [1:0] sz, input logic sg, input logic [31:0] rdat,
                       input int dly, input logic junk);
        req_t  r;
        done_t d;
        @(posedge clk); #1;
        rd_start = rd; wr_start = wr; mdr_in = mi; bus_in = bi; size = sz; sign = sg;
        mem_rdata = $urandom;
        if (mi) model_mdr = bi;
        if (rd || wr) begin
            r.we = !rd; r.be = ref_be(sz); r.wdata = model_mdr;
            exp_req.push_back(r);
            if (rd) model_mdr = ref_ext(rdat, sz, sg);
            d.mdr = model_mdr; d.err = 1'b0;
            exp_done.push_back(d);
            n_exp_done++;
        end
        @(posedge clk); #1;
        rd_start = 1'b0; wr_start = 1'b0; mdr_in = 1'b0;
        if (!(rd || wr)) begin
            check("mdr_load", mdr_out, model_mdr);
            check("load_busy", 32'(busy), 32'd0);
            return;
        end
        repeat (dly) begin
            if (junk) junk_inputs();
            @(posedge clk); #1;
        end
        if (junk) junk_inputs();
        mem_ack = 1'b1; mem_rdata = rdat;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        if (junk) begin junk_inputs(); mem_ack = 1'(1); end
        @(posedge clk); #1;
        rd_start = 1'b0; wr_start = 1'b0; mdr_in = 1'b0; mem_ack = 1'b0;
    endtask

    task automatic idle_noise();
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1; mem_ack = 1'b0;
    endtask

    initial begin
        req_t r;
        clr = 1'b0; bus_in = 32'h0; mdr_in = 1'b0; rd_start = 1'b0; wr_start = 1'b0;
        size = 2'b00; sign = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mdr", mdr_out, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        clr = 1'b1;

        txn(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        check("load_deadbeef", mdr_out, 32'hDEADBEEF);
        txn(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 1'b1, 32'h12345680, 2, 1'b0);
        check("rd_byte_sext", mdr_out, 32'hFFFFFF80);
        txn(1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 1'b0, 32'hFFFF8001, 1, 1'b0);
        check("rd_half_zext", mdr_out, 32'h00008001);
        txn(1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 2'b10, 1'b0, 32'h0, 0, 1'b0);
        txn(1'b0, 1'b1, 1'b0, 32'h0, 2'b01, 1'b0, 32'h11112222, 3, 1'b1);
        check("wr_mdr_kept", mdr_out, 32'hCAFEF00D);
        txn(1'b1, 1'b1, 1'b0, 32'h0, 2'b11, 1'b0, 32'h0BADC0DE, 1, 1'b0);
        check("rd_wins", mdr_out, 32'h0BADC0DE);

        // Reset in the middle of a read: no completion, later ack ignored.
        @(posedge clk); #1;
        rd_start = 1'b1; size = 2'b00; sign = 1'b0;
        r.we = 1'b0; r.be = 4'h1; r.wdata = model_mdr;
        exp_req.push_back(r);
        @(posedge clk); #1; rd_start = 1'b0;
        @(posedge clk); #1; clr = 1'b0; #1;
        model_mdr = 32'h0;
        check("abort_mdr", mdr_out, 32'h0);
        check("abort_req", 32'(mem_req), 32'd0);
        check("abort_be", 32'(mem_be), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        @(posedge clk); #1; clr = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55555555;
        @(posedge clk); #1; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_ack_ignored", mdr_out, 32'h0);
        idle_noise();

        for (int i = 0; i < 60; i++) begin
            int op;
            op = $urandom_range(0, 3);
            txn(1'(op == 1 || op == 3), 1'(op >= 2), 1'($urandom_range(0, 1)), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), 1'b1);
            if ($urandom_range(0, 3) == 0) idle_noise();
        end

`ifdef MDR_TIMEOUT_EN
        begin
            done_t d;
            int    n;
            @(posedge clk); #1;
            rd_start = 1'b1; size = 2'b10;
            r.we = 1'b0; r.be = 4'hF; r.wdata = model_mdr;
            exp_req.push_back(r);
            d.mdr = model_mdr; d.err = 1'b1;
            exp_done.push_back(d);
            n_exp_done++;
            @(posedge clk); #1; rd_start = 1'b0;
            n = 0;
            while (!done && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd4);
            @(posedge clk); #1;
            check("err_sticky", 32'(err), 32'd1);
            check("timeout_idle", 32'(busy), 32'd0);
            txn(1'b0, 1'b1, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1, 1'b0);
            check("err_cleared", 32'(err), 32'd0);
        end
`endif

        repeat (4) @(posedge clk);
        #1;
        check("req_queue_empty", 32'(exp_req.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done.size()), 32'd0);
        check("done_pulse_count", 32'(done_cnt), 32'(n_exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mdr_bus_if.md
MDR_BUS_IF -- requirements
Module: mdr_bus_if

Interface
REQ-001 Parameter WIDTH, 32, data width in bits; legal values are 16, 32 or 64.
REQ-002 Parameter TIMEOUT, 16, maximum cycles spent waiting for mem_ack; only used when MDR_TIMEOUT_EN is defined.
REQ-003 Port clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 Port clr  in  1  reset, asynchronous, active-low (clr=0 resets).
REQ-005 Port bus_in  in  WIDTH  internal bus value (BusMuxOut).
REQ-006 Port mdr_in  in  1  load MDR from bus_in.
REQ-007 Port rd_start  in  1  start a memory read into MDR.
REQ-008 Port wr_start  in  1  start a memory write of MDR.
REQ-009 Port size  in  2  access size: 00 byte, 01 half, 10 full WIDTH, 11 is treated as 10.
REQ-010 Port sign  in  1  read extension: 1 sign-extend, 0 zero-extend.
REQ-011 Port mem_rdata  in  WIDTH  memory read data.
REQ-012 Port mem_ack  in  1  memory completion strobe.
REQ-013 Port mem_req  out  1  memory request.
REQ-014 Port mem_we  out  1  write qualifier for mem_req.
REQ-015 Port mem_be  out  WIDTH/8  byte-lane enables.
REQ-016 Port mem_wdata  out  WIDTH  write data, equal to mdr_out.
REQ-017 Port mdr_out  out  WIDTH  MDR contents.
REQ-018 Port busy  out  1  high in any state other than IDLE.
REQ-019 Port done  out  1  one-cycle completion pulse.
REQ-020 Port err  out  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, RD_WAIT, WR_WAIT, DONE; all outputs are registered.
REQ-022 IDLE, rd_start=1: latch size and sign, go to RD_WAIT; rd_start takes priority over a simultaneous wr_start.
REQ-023 IDLE, wr_start=1 and rd_start=0: latch size, go to WR_WAIT.
REQ-024 mem_req rises the cycle after the start is sampled and stays high throughout the WAIT state; mem_we=1 only in WR_WAIT.
REQ-025 mem_be: byte 0x1, half 0x3, full all ones; lanes always start at lane 0; mem_be is 0 when mem_req=0.
REQ-026 mem_ack is sampled only in WAIT states and is ignored in IDLE and DONE.
REQ-027 RD_WAIT with mem_ack=1: MDR <= extend(mem_rdata, size, sign) on that edge, go to DONE.
REQ-028 WR_WAIT with mem_ack=1: MDR unchanged, go to DONE.
REQ-029 DONE: done=1 and busy=1 for exactly one cycle, then IDLE; minimum start-to-done latency is 3 cycles.
REQ-030 mdr_in=1 in IDLE loads bus_in on that edge; if rd_start is also 1, the load happens and the later read result overwrites it.
REQ-031 While busy=1, mdr_in, rd_start and wr_start are ignored; MDR is stable during writes.
REQ-032 Extension: byte replicates bit 7 (sign=1) or fills with zeros; half does the same using bit 15; full passes data unchanged.

Reset
REQ-033 clr=0 asynchronously forces state IDLE, MDR=0, mem_req=0, mem_we=0, mem_be=0, done=0, busy=0, err=0 and the timeout counter to 0.
REQ-034 Reset during a WAIT state abandons the transfer without a done pulse; a mem_ack arriving afterwards is ignored.

Configuration
REQ-035 With MDR_TIMEOUT_EN defined, a counter runs in WAIT states; TIMEOUT cycles without mem_ack moves the FSM to DONE with MDR unchanged and err=1.
REQ-036 With MDR_TIMEOUT_EN defined, err stays set until the next accepted start or reset; mem_ack on the timeout cycle wins and err stays 0.
REQ-037 Without MDR_TIMEOUT_EN, no counter is built, err is tied to 0, and WAIT states wait indefinitely.

Structure
REQ-038 Package mdr_pkg holds the state enum and the size encodings (SZ_BYTE, SZ_HALF, SZ_FULL).
REQ-039 One combinational sub-module, mdr_extend, parametrised by WIDTH, performs extension and generates mem_be.

Verification
REQ-040 WIDTH=32: mdr_in=1, bus_in=0xDEADBEEF -> mdr_out=0xDEADBEEF next cycle, busy stays 0.
REQ-041 Read, size=00, sign=1, mem_rdata=0x12345680, ack 2 cycles after mem_req -> mdr_out=0xFFFFFF80, one done pulse.
REQ-042 Read, size=01, sign=0, mem_rdata=0xFFFF8001 -> mdr_out=0x00008001.
REQ-043 Write with MDR=0xCAFEF00D, size=01 -> mem_we=1, mem_be=0x3, mem_wdata=0xCAFEF00D until ack; wr_start while busy is ignored.
REQ-044 rd_start and wr_start together -> read performed (mem_we=0); clr=0 mid-RD_WAIT -> all outputs 0, no done pulse.
REQ-045 MDR_TIMEOUT_EN, TIMEOUT=4, no ack -> done after 4 WAIT cycles, err=1, MDR unchanged; err clears on next start.
